// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state encoding.
// Pure declarations, no logic, no latency, no backpressure.
package apb_pkg;

   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: each lane takes the write data when its strobe is set, else keeps the old word.
// Purely combinational (zero latency), no flow control.
module apb_strb_merge
   import apb_pkg::*;
(
   input  logic [APB_DATA_W-1:0] old_word,
   input  logic [APB_DATA_W-1:0] wdata,
   input  logic [APB_STRB_W-1:0] strb,
   output logic [APB_DATA_W-1:0] new_word
);

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < APB_STRB_W; i++) begin
         if (strb[i]) begin
            new_word[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/apb_strb_completer.sv
// APB completer over NREGS 32-bit registers with byte strobes; PREADY in ACCESS cycle WAIT_CYCLES+1, PSEL drop aborts.
// Define APB_COMPLETER_PROT_EN to add PPROT and reject unprivileged writes to register 0.
module apb_strb_completer
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int NREGS       = 16,
   parameter int WAIT_CYCLES = 1
)
(
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_W-1:0]     PADDR,
   input  logic [APB_DATA_W-1:0] PWDATA,
   input  logic [APB_STRB_W-1:0] PSTRB,
`ifdef APB_COMPLETER_PROT_EN
   input  logic [2:0]            PPROT,
`endif
   output logic [APB_DATA_W-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int                RIDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W-2:0] NREGS_L = (ADDR_W-1)'(NREGS);
   localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

   apb_state_t state;
   apb_state_t state_nxt;
   logic [3:0] wait_cnt;

   logic                  write_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [APB_DATA_W-1:0] wdata_q;
   logic [APB_STRB_W-1:0] strb_q;
`ifdef APB_COMPLETER_PROT_EN
   logic                  priv_q;
`endif

   logic [APB_DATA_W-1:0] regs [NREGS];

   logic [ADDR_W-3:0]     idx;
   logic [RIDX_W-1:0]     ridx;
   logic                  addr_err;
   logic                  strb_err;
   logic                  prot_err;
   logic                  err;
   logic                  done;
   logic                  wr_en;
   logic [APB_DATA_W-1:0] cur_word;
   logic [APB_DATA_W-1:0] merged;

   assign idx      = addr_q[ADDR_W-1:2];
   assign ridx     = idx[RIDX_W-1:0];
   assign cur_word = regs[ridx];
   assign addr_err = ({1'b0, idx} >= NREGS_L) || (addr_q[1:0] != 2'b00);
   assign strb_err = !write_q && (strb_q != '0);
`ifdef APB_COMPLETER_PROT_EN
   assign prot_err = write_q && (idx == '0) && !priv_q;
`else
   assign prot_err = 1'b0;
`endif
   assign err      = addr_err || strb_err || prot_err;

   // Outputs decode straight from registered state so reset clears them without waiting for a clock.
   assign done    = (state == ACCESS) && (wait_cnt == WAIT_L);
   assign PREADY  = done;
   assign PSLVERR = done && err;
   assign PRDATA  = (done && !write_q && !err) ? cur_word : '0;
   assign wr_en   = done && write_q && !err;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done || !PSEL) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state    <= IDLE;
         wait_cnt <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
`ifdef APB_COMPLETER_PROT_EN
         priv_q   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (state == IDLE && PSEL && !PENABLE) begin
            write_q <= PWRITE;
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
`ifdef APB_COMPLETER_PROT_EN
            priv_q  <= PPROT[0];
`endif
         end
         if (state == SETUP) begin
            wait_cnt <= '0;
         end else if (state == ACCESS && !done) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[ridx] <= merged;
      end
   end

   apb_strb_merge u_merge (
      .old_word (cur_word),
      .wdata    (wdata_q),
      .strb     (strb_q),
      .new_word (merged)
   );

endmodule

// File: tb/tb_apb_strb_completer.sv
// Scoreboard bench: one completer with one wait state, one with three for abort and latency cases.
// Drivers push expected responses; a negedge monitor pops and compares on every PREADY.
module tb_apb_strb_completer;

   localparam int WAIT_A = 1;
   localparam int WAIT_B = 3;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        psel_a, psel_b, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
`ifdef APB_COMPLETER_PROT_EN
   logic [2:0]  pprot;
`endif
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;

   always #5 pclk = ~pclk;

   apb_strb_completer #(.ADDR_W(8), .NREGS(16), .WAIT_CYCLES(WAIT_A)) dut_a (
      .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB_COMPLETER_PROT_EN
      .PPROT(pprot),
`endif
      .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
   );

   apb_strb_completer #(.ADDR_W(8), .NREGS(16), .WAIT_CYCLES(WAIT_B)) dut_b (
      .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
`ifdef APB_COMPLETER_PROT_EN
      .PPROT(pprot),
`endif
      .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   exp_t        mon_e;
   logic [31:0] mon_d;
   logic        mon_s;

   always @(negedge pclk) begin
      if (presetn) begin
         if (pready_a || pready_b) begin
            mon_d = pready_a ? prdata_a : prdata_b;
            mon_s = pready_a ? pslverr_a : pslverr_b;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_pready: got prdata=%h pslverr=%0b, required no completion", mon_d, mon_s);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_d !== mon_e.rdata || mon_s !== mon_e.err) begin
                  n_err++;
                  $display("FAIL response: got prdata=%h pslverr=%0b, required prdata=%h pslverr=%0b",
                           mon_d, mon_s, mon_e.rdata, mon_e.err);
               end
            end
         end else begin
            n_vec++;
            if (prdata_a !== 32'h0 || pslverr_a !== 1'b0 || prdata_b !== 32'h0 || pslverr_b !== 1'b0) begin
               n_err++;
               $display("FAIL idle_outputs: got prdata=%h/%h pslverr=%0b/%0b, required all 0",
                        prdata_a, prdata_b, pslverr_a, pslverr_b);
            end
         end
      end
   end

   // Drive setup, then access phase until PREADY; n counts negedges from the SETUP-state cycle.
   task automatic start_xfer(input bit use_b, input bit wr, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [31:0] exp_rdata, input bit exp_err);
      exp_q.push_back(exp_t'{rdata: exp_rdata, err: exp_err});
      psel_a  = !use_b;
      psel_b  = use_b;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      @(posedge pclk);
      #1 penable = 1'b1;
   endtask

   task automatic wait_ready(input bit use_b, output bit seen);
      int n;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge pclk);
         n++;
         seen = use_b ? pready_b : pready_a;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL timeout: got no PREADY within %0d cycles, required one", n);
         if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      end else if (n - 1 != (use_b ? WAIT_B : WAIT_A) + 1) begin
         n_err++;
         $display("FAIL latency: got PREADY in access cycle %0d, required %0d",
                  n - 1, (use_b ? WAIT_B : WAIT_A) + 1);
      end
   endtask

   task automatic xfer(input bit use_b, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rdata, input bit exp_err);
      bit seen;
      start_xfer(use_b, wr, addr, wdata, strb, exp_rdata, exp_err);
      wait_ready(use_b, seen);
      @(posedge pclk);
      #1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got simulation still running, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      bit any_ready;
      presetn = 1'b0;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
`ifdef APB_COMPLETER_PROT_EN
      pprot   = 3'b001;
`endif
      repeat (3) @(posedge pclk);
      #1;
      n_vec++;
      if (pready_a !== 1'b0 || pready_b !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pready: got %0b/%0b, required 0", pready_a, pready_b);
      end
      n_vec++;
      if (pslverr_a !== 1'b0 || pslverr_b !== 1'b0) begin
         n_err++;
         $display("FAIL reset_pslverr: got %0b/%0b, required 0", pslverr_a, pslverr_b);
      end
      n_vec++;
      if (prdata_a !== 32'h0 || prdata_b !== 32'h0) begin
         n_err++;
         $display("FAIL reset_prdata: got %h/%h, required 0", prdata_a, prdata_b);
      end
      presetn = 1'b1;
      @(posedge pclk);
      #1;

      // use_b, wr, addr, wdata, strb, expected prdata, expected pslverr
      xfer(0, 1, 8'h04, 32'hDEADBEEF, 4'b1111, 32'h0,        0);
      xfer(0, 0, 8'h04, 32'h0,        4'b0000, 32'hDEADBEEF, 0);
      xfer(0, 1, 8'h08, 32'h11223344, 4'b1111, 32'h0,        0);
      xfer(0, 1, 8'h08, 32'hAABBCCDD, 4'b0101, 32'h0,        0);
      xfer(0, 0, 8'h08, 32'h0,        4'b0000, 32'h11BB33DD, 0);
      xfer(0, 1, 8'h08, 32'h99999999, 4'b0000, 32'h0,        0);
      xfer(0, 0, 8'h08, 32'h0,        4'b0000, 32'h11BB33DD, 0);
      xfer(0, 0, 8'h40, 32'h0,        4'b0000, 32'h0,        1);
      xfer(0, 1, 8'h06, 32'hFFFFFFFF, 4'b1111, 32'h0,        1);
      xfer(0, 0, 8'h04, 32'h0,        4'b0000, 32'hDEADBEEF, 0);
      xfer(0, 0, 8'h04, 32'h0,        4'b0001, 32'h0,        1);
      xfer(0, 1, 8'h3C, 32'h0F0F0F0F, 4'b1000, 32'h0,        0);
      xfer(0, 0, 8'h3C, 32'h0,        4'b0000, 32'h0F000000, 0);
      xfer(0, 0, 8'h3D, 32'h0,        4'b0000, 32'h0,        1);

`ifdef APB_COMPLETER_PROT_EN
      pprot = 3'b000;
      xfer(0, 1, 8'h00, 32'h55AA55AA, 4'b1111, 32'h0,        1);
      xfer(0, 0, 8'h00, 32'h0,        4'b0000, 32'h0,        0);
      pprot = 3'b001;
      xfer(0, 1, 8'h00, 32'h55AA55AA, 4'b1111, 32'h0,        0);
      xfer(0, 0, 8'h00, 32'h0,        4'b0000, 32'h55AA55AA, 0);
`endif

      // Abort on the three-wait-state completer: PSEL drops in the first ACCESS cycle.
      xfer(1, 1, 8'h0C, 32'h12345678, 4'b1111, 32'h0, 0);
      psel_b  = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h0C;
      pwdata  = 32'hFFFFFFFF;
      pstrb   = 4'b1111;
      @(posedge pclk);
      #1 penable = 1'b1;
      @(posedge pclk);
      #1;
      psel_b  = 1'b0;
      penable = 1'b0;
      any_ready = 1'b0;
      repeat (8) begin
         @(negedge pclk);
         if (pready_b) any_ready = 1'b1;
      end
      n_vec++;
      if (any_ready) begin
         n_err++;
         $display("FAIL abort_pready: got PREADY after abort, required none");
      end
      @(posedge pclk);
      #1;
      xfer(1, 0, 8'h0C, 32'h0, 4'b0000, 32'h12345678, 0);

      // Reset asserted in the PREADY cycle of a write: outputs drop at once, nothing is written.
      start_xfer(0, 1, 8'h10, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
      wait_ready(0, seen);
      #2 presetn = 1'b0;
      #1;
      n_vec++;
      if (pready_a !== 1'b0 || pslverr_a !== 1'b0 || prdata_a !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got pready=%0b pslverr=%0b prdata=%h, required 0",
                  pready_a, pslverr_a, prdata_a);
      end
      psel_a  = 1'b0;
      penable = 1'b0;
      @(posedge pclk);
      #1 presetn = 1'b1;
      @(posedge pclk);
      #1;
      xfer(0, 0, 8'h10, 32'h0, 4'b0000, 32'h0, 0);
      xfer(0, 0, 8'h04, 32'h0, 4'b0000, 32'h0, 0);
      xfer(0, 0, 8'h08, 32'h0, 4'b0000, 32'h0, 0);
      xfer(0, 0, 8'h3C, 32'h0, 4'b0000, 32'h0, 0);
      xfer(1, 0, 8'h0C, 32'h0, 4'b0000, 32'h0, 0);

      repeat (2) @(posedge pclk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover_expected: got %0d unmatched responses, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_strb_completer.md
APB_STRB_COMPLETER -- requirements
Module: apb_strb_completer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning PADDR width in bits.
REQ-002 SHALL have parameter NREGS, default 16, meaning number of 32-bit registers (power of two, NREGS*4 <= 2^ADDR_W).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, meaning access-phase wait states before PREADY (0..15).
REQ-004 SHALL have ports, in this order:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte-lane strobes.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
REQ-005 SHALL use one clock, PCLK; reset PRESETn is asynchronous, active-low.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS.
- IDLE->SETUP on PSEL=1 & PENABLE=0.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on PREADY=1, or on PSEL=0 (abort).
REQ-007 SHALL clear the wait counter on entry to ACCESS and increment it each ACCESS cycle with PREADY=0.
REQ-008 SHALL assert PREADY only in ACCESS when counter == WAIT_CYCLES; WAIT_CYCLES=0 gives PREADY in the first ACCESS cycle.
REQ-009 SHALL capture PADDR, PWRITE, PWDATA and PSTRB in SETUP and use only the captured values thereafter.
REQ-010 SHALL decode register index PADDR[ADDR_W-1:2]; index >= NREGS or PADDR[1:0] != 0 is an address error.
REQ-011 SHALL flag a read with PSTRB != 0 as a strobe error.
REQ-012 SHALL, on the PREADY cycle of an error-free write, update byte lane i of the addressed register iff PSTRB[i]=1 and leave the other lanes unchanged.
- PSTRB=0000 completes with PSLVERR=0 and no update.
REQ-013 SHALL drive PRDATA with the addressed register in the PREADY cycle of an error-free read, and 0 at all other times.
REQ-014 SHALL assert PSLVERR only in the PREADY cycle of an errored transfer; errored writes modify nothing, and errored reads return PRDATA=0.
REQ-015 SHALL, on abort (PSEL falling in ACCESS before PREADY), perform no write and return to IDLE.
REQ-016 SHALL support back-to-back transfers: a new SETUP may occur in the cycle after PREADY.

Reset
REQ-017 SHALL, while PRESETn=0, force state IDLE, wait counter 0, all registers 0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-018 SHALL discard any in-flight transfer on reset assertion, with no partial write.

Configuration
REQ-019 SHALL, with APB_COMPLETER_PROT_EN defined, add input PPROT (width 3) after PSTRB, captured in SETUP; a write to register 0 with PPROT[0]=0 is then an error (PSLVERR=1, no update).
REQ-020 SHALL, without APB_COMPLETER_PROT_EN, have no PPROT port and no privilege check.

Structure
REQ-021 SHALL take the state enum and the constants APB_DATA_W=32 and APB_STRB_W=4 from the shared package apb_pkg.
REQ-022 SHALL place the per-lane merge (old word, PWDATA, PSTRB -> new word) in sub-module apb_strb_merge.

Verification
REQ-023 Full write then read: WAIT_CYCLES=1; write 0x04 = 0xDEADBEEF, PSTRB=1111 -> PREADY in the 2nd ACCESS cycle; read 0x04 -> PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-024 Partial strobe: reg 0x08 = 0x11223344; write 0xAABBCCDD with PSTRB=0101 -> read returns 0x11BB33DD.
REQ-025 Errors: read 0x40 with NREGS=16 -> PSLVERR=1, PRDATA=0; write 0x06 -> PSLVERR=1, register 1 unchanged; read with PSTRB=0001 -> PSLVERR=1.
REQ-026 Abort: drop PSEL in the first ACCESS cycle of a write, WAIT_CYCLES=3 -> no PREADY, target register unchanged, FSM back in IDLE.
REQ-027 Reset mid-transfer: assert PRESETn=0 during ACCESS of a write -> outputs 0 immediately, all registers 0.
REQ-028 With APB_COMPLETER_PROT_EN: write reg 0 with PPROT=000 -> PSLVERR=1, no update; repeat with PPROT=001 -> update, PSLVERR=0.
